ddr3_dfi_sequencer: RTL and testbench

Command sequencer directly upstream of the DDR3 PHY. It accepts memory-controller commands over a valid/ready handshake and buffers write data. It drives the PHY's DFI command, write and read-enable pins with per-command spacing enforced, and forwards the PHY's captured read data to the controller.

---
 rtl/ddr3_dfi_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_ddr3_dfi_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_dfi_sequencer.sv
// DDR3 DFI command sequencer: spaces controller commands, buffers write
// data, times DFI wren/rden/odt windows and registers PHY read return.
module ddr3_dfi_sequencer #(
  parameter int DDR3_WIDTH  = 16,
  parameter int ADDR_BITS   = 14,
  parameter int WR_LATENCY  = 3,
  parameter int RD_LATENCY  = 3,
  parameter int WFIFO_DEPTH = 8,
  parameter int GAP_ACT     = 4,
  parameter int GAP_RD      = 4,
  parameter int GAP_WR      = 8,
  parameter int GAP_PRE     = 4,
  parameter int GAP_REF     = 32,
  parameter int GAP_MRS     = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ctl_cke_i,
  input  logic                      ctl_rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [2:0]                cmd_code_i,
  input  logic [2:0]                cmd_bank_i,
  input  logic [ADDR_BITS-1:0]      cmd_addr_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [DDR3_WIDTH/4-1:0]   wr_mask_i,
  input  logic [2*DDR3_WIDTH-1:0]   wr_data_i,
  output logic                      rd_valid_o,
  output logic [2*DDR3_WIDTH-1:0]   rd_data_o,
  output logic                      dfi_cke_o,
  output logic                      dfi_rst_no,
  output logic                      dfi_cs_no,
  output logic                      dfi_ras_no,
  output logic                      dfi_cas_no,
  output logic                      dfi_we_no,
  output logic                      dfi_odt_o,
  output logic [2:0]                dfi_bank_o,
  output logic [ADDR_BITS-1:0]      dfi_addr_o,
  output logic                      dfi_wren_o,
  output logic [DDR3_WIDTH/4-1:0]   dfi_mask_o,
  output logic [2*DDR3_WIDTH-1:0]   dfi_data_o,
  output logic                      dfi_rden_o,
  input  logic                      dfi_valid_i,
  input  logic [2*DDR3_WIDTH-1:0]   dfi_data_i
);
  localparam int DW = 2 * DDR3_WIDTH;
  localparam int MW = DDR3_WIDTH / 4;
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;
  localparam logic [2:0] C_MRS = 3'd6;
  localparam logic [3:0] E_NOP = 4'b0111;

  typedef enum logic {S_READY, S_WAIT} state_t;

  state_t              state;
  logic [15:0]         gap_cnt;
  logic                live;
  logic [CW-1:0]       count;
  logic [CW-1:0]       avail;
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [DW+MW-1:0]    mem [WFIFO_DEPTH];
  logic [WR_LATENCY+3:0] wsr;
  logic [RD_LATENCY+3:0] rsr;
  logic [WR_LATENCY+4:0] osr;

  logic is_wr, is_nop, accept, push, pop;

  function automatic logic [15:0] gap_of(input logic [2:0] c);
    case (c)
      C_ACT:   gap_of = 16'(GAP_ACT);
      C_RD:    gap_of = 16'(GAP_RD);
      C_WR:    gap_of = 16'(GAP_WR);
      C_PRE:   gap_of = 16'(GAP_PRE);
      C_REF:   gap_of = 16'(GAP_REF);
      C_MRS:   gap_of = 16'(GAP_MRS);
      default: gap_of = 16'd1;
    endcase
  endfunction

  function automatic logic [3:0] enc(input logic [2:0] c);
    case (c)
      C_ACT:   enc = 4'b0011;
      C_RD:    enc = 4'b0101;
      C_WR:    enc = 4'b0100;
      C_PRE:   enc = 4'b0010;
      C_REF:   enc = 4'b0001;
      C_MRS:   enc = 4'b0000;
      default: enc = E_NOP;
    endcase
  endfunction

  // avail counts words not yet claimed by an accepted WR burst
  assign is_wr  = cmd_code_i == C_WR;
  assign is_nop = cmd_code_i == 3'd0 || cmd_code_i == 3'd7;
  assign cmd_ready_o = live && state == S_READY
                    && !(is_wr && avail < CW'(4));
  assign accept = cmd_valid_i && cmd_ready_o;
  assign wr_ready_o = live && count != CW'(WFIFO_DEPTH);
  assign push = wr_valid_i && wr_ready_o;
  assign pop  = wsr[1];
  assign dfi_wren_o = wsr[0];
  assign dfi_rden_o = rsr[0];
  assign dfi_odt_o  = osr[0];

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= {wr_mask_i, wr_data_i};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      live       <= 1'b0;
      state      <= S_READY;
      gap_cnt    <= '0;
      dfi_cke_o  <= 1'b0;
      dfi_rst_no <= 1'b0;
      {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= E_NOP;
      dfi_bank_o <= '0;
      dfi_addr_o <= '0;
      wsr        <= '0;
      rsr        <= '0;
      osr        <= '0;
      count      <= '0;
      avail      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      dfi_mask_o <= '0;
      dfi_data_o <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      live       <= 1'b1;
      dfi_cke_o  <= ctl_cke_i;
      dfi_rst_no <= ctl_rst_ni;
      rd_valid_o <= dfi_valid_i;
      rd_data_o  <= dfi_data_i;
      {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= E_NOP;
      wsr <= wsr >> 1;
      rsr <= rsr >> 1;
      osr <= osr >> 1;
      case (state)
        S_READY: begin
          if (accept && !is_nop) begin
            {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no}
              <= enc(cmd_code_i);
            dfi_bank_o <= cmd_bank_i;
            dfi_addr_o <= cmd_addr_i;
            if (gap_of(cmd_code_i) > 16'd1) begin
              state   <= S_WAIT;
              gap_cnt <= gap_of(cmd_code_i) - 16'd2;
            end
            if (is_wr) begin
              wsr <= (wsr >> 1) | {4'hF, {WR_LATENCY{1'b0}}};
              osr <= '1;
            end
            if (cmd_code_i == C_RD)
              rsr <= (rsr >> 1) | {4'hF, {RD_LATENCY{1'b0}}};
          end
        end
        S_WAIT: begin
          if (gap_cnt == 16'd0) state <= S_READY;
          else gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= S_READY;
      endcase
      if (push) wptr <= wptr + PW'(1);
      // data is fetched one clock ahead so it lines up with wren
      if (pop) begin
        {dfi_mask_o, dfi_data_o} <= mem[rptr];
        rptr <= rptr + PW'(1);
      end else begin
        dfi_mask_o <= '0;
        dfi_data_o <= '0;
      end
      count <= count + CW'(push) - CW'(pop);
      avail <= avail + CW'(push)
             - ((accept && is_wr) ? CW'(4) : CW'(0));
    end
  end
endmodule

// File: tb/tb_ddr3_dfi_sequencer.sv
// Directed bench for ddr3_dfi_sequencer: command timing, write/read
// windows, FIFO hold-off and full handling, reset during a burst.
module tb_ddr3_dfi_sequencer;
  localparam int GAP_WR = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctl_cke_i, ctl_rst_ni;
  logic        cmd_valid_i, cmd_ready_o;
  logic [2:0]  cmd_code_i, cmd_bank_i;
  logic [13:0] cmd_addr_i;
  logic        wr_valid_i, wr_ready_o;
  logic [3:0]  wr_mask_i;
  logic [31:0] wr_data_i;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no;
  logic        dfi_cas_no, dfi_we_no, dfi_odt_o;
  logic [2:0]  dfi_bank_o;
  logic [13:0] dfi_addr_o;
  logic        dfi_wren_o, dfi_rden_o, dfi_valid_i;
  logic [3:0]  dfi_mask_o;
  logic [31:0] dfi_data_o, dfi_data_i;
  logic [3:0]  cmd;

  int pass_n = 0;
  int tot_n  = 0;

  assign cmd = {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no};

  always #5 clock = ~clock;

  ddr3_dfi_sequencer #(.GAP_WR(GAP_WR)) dut (
    .clock(clock), .reset(reset),
    .ctl_cke_i(ctl_cke_i), .ctl_rst_ni(ctl_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_code_i(cmd_code_i), .cmd_bank_i(cmd_bank_i),
    .cmd_addr_i(cmd_addr_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_mask_i(wr_mask_i), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .dfi_cke_o(dfi_cke_o), .dfi_rst_no(dfi_rst_no),
    .dfi_cs_no(dfi_cs_no), .dfi_ras_no(dfi_ras_no),
    .dfi_cas_no(dfi_cas_no), .dfi_we_no(dfi_we_no),
    .dfi_odt_o(dfi_odt_o), .dfi_bank_o(dfi_bank_o),
    .dfi_addr_o(dfi_addr_o), .dfi_wren_o(dfi_wren_o),
    .dfi_mask_o(dfi_mask_o), .dfi_data_o(dfi_data_o),
    .dfi_rden_o(dfi_rden_o), .dfi_valid_i(dfi_valid_i),
    .dfi_data_i(dfi_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tot_n++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      pass_n++;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] m);
    @(negedge clock);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    wr_mask_i  = m;
    #1 chk("push_rdy", 32'(wr_ready_o), 32'd1);
    @(negedge clock);
    wr_valid_i = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [2:0] c,
                       input logic [2:0] ba, input logic [13:0] a);
    @(negedge clock);
    cmd_valid_i = 1'b1;
    cmd_code_i  = c;
    cmd_bank_i  = ba;
    cmd_addr_i  = a;
    #1 chk({tag, "_rdy"}, 32'(cmd_ready_o), 32'd1);
  endtask

  // Steps N+1..N+9 after a WR accepted at N
  task automatic wr_burst(input string tag, input logic [31:0] e [4],
                          input logic [3:0] m);
    logic drop;
    drop = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      cmd_valid_i = 1'b0;
      cmd_code_i  = 3'd0;
      if (drop) wr_valid_i = 1'b0;
      #1;
      if (i == 1) chk({tag, "_cmd"}, 32'(cmd), 32'(4'b0100));
      if (i == 2) chk({tag, "_nop"}, 32'(cmd), 32'(4'b0111));
      chk({tag, "_wren"}, 32'(dfi_wren_o), 32'(i >= 4 && i <= 7));
      chk({tag, "_odt"}, 32'(dfi_odt_o), 32'(i <= 8));
      if (i >= 4 && i <= 7) begin
        chk({tag, "_data"}, dfi_data_o, e[i-4]);
        chk({tag, "_mask"}, 32'(dfi_mask_o), 32'(m));
      end
      drop = wr_valid_i && wr_ready_o;
    end
  endtask

  initial begin
    assert (GAP_WR >= 4)
      else $fatal(1, "FAIL gap_wr_cfg got=%0d exp>=4", GAP_WR);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ctl_cke_i = 1'b1; ctl_rst_ni = 1'b1;
    cmd_valid_i = 1'b0; cmd_code_i = 3'd0;
    cmd_bank_i = 3'd0; cmd_addr_i = 14'd0;
    wr_valid_i = 1'b0; wr_mask_i = 4'd0; wr_data_i = 32'd0;
    dfi_valid_i = 1'b0; dfi_data_i = 32'd0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_cmd_rdy", 32'(cmd_ready_o), 32'd0);
    chk("rst_wr_rdy", 32'(wr_ready_o), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'(4'b0111));
    chk("rst_cke", 32'(dfi_cke_o), 32'd0);
    chk("rst_rstn", 32'(dfi_rst_no), 32'd0);
    chk("rst_wren", 32'(dfi_wren_o), 32'd0);
    chk("rst_odt", 32'(dfi_odt_o), 32'd0);
    chk("rst_rdv", 32'(rd_valid_o), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("live_cmd_rdy", 32'(cmd_ready_o), 32'd1);
    chk("live_wr_rdy", 32'(wr_ready_o), 32'd1);
    chk("live_cke", 32'(dfi_cke_o), 32'd1);
    chk("live_rstn", 32'(dfi_rst_no), 32'd1);

    // ACT bank 2 row 0x155
    issue("act", 3'd1, 3'd2, 14'h155);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      cmd_valid_i = 1'b0;
      cmd_code_i  = 3'd0;
      #1;
      chk("act_gap", 32'(cmd_ready_o), 32'(i == 4));
      if (i == 1) begin
        chk("act_cmd", 32'(cmd), 32'(4'b0011));
        chk("act_bank", 32'(dfi_bank_o), 32'd2);
        chk("act_addr", 32'(dfi_addr_o), 32'h155);
      end
      if (i == 2) chk("act_nop", 32'(cmd), 32'(4'b0111));
    end

    // code 7 is a NOP and leaves the sequencer ready
    issue("nop7", 3'd7, 3'd1, 14'h3);
    @(negedge clock);
    cmd_valid_i = 1'b0;
    #1;
    chk("nop7_cmd", 32'(cmd), 32'(4'b0111));
    chk("nop7_rdy", 32'(cmd_ready_o), 32'd1);

    // WR with 4 buffered words
    for (int k = 0; k < 4; k++) push(32'hA0 + k, 4'h0);
    issue("wr1", 3'd3, 3'd0, 14'h10);
    wr_burst("wr1", '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 4'h0);

    // WR held off with 3 words, accepted once the 4th lands
    for (int k = 0; k < 3; k++) push(32'hB0 + k, 4'h5);
    @(negedge clock);
    cmd_valid_i = 1'b1; cmd_code_i = 3'd3; cmd_addr_i = 14'h18;
    wr_valid_i = 1'b1; wr_data_i = 32'hB3; wr_mask_i = 4'h5;
    #1 chk("wr2_hold", 32'(cmd_ready_o), 32'd0);
    @(negedge clock);
    wr_valid_i = 1'b0;
    #1 chk("wr2_rdy", 32'(cmd_ready_o), 32'd1);
    wr_burst("wr2", '{32'hB0, 32'hB1, 32'hB2, 32'hB3}, 4'h5);

    // RD and read return
    issue("rd", 3'd2, 3'd3, 14'h20);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      cmd_valid_i = 1'b0;
      cmd_code_i  = 3'd0;
      #1;
      if (i == 1) chk("rd_cmd", 32'(cmd), 32'(4'b0101));
      chk("rd_rden", 32'(dfi_rden_o), 32'(i >= 4 && i <= 7));
      chk("rd_valid", 32'(rd_valid_o), 32'(i >= 11 && i <= 14));
      if (i >= 11 && i <= 14)
        chk("rd_data", rd_data_o, 32'h11 + 32'(i - 11));
      dfi_valid_i = (i >= 10 && i <= 13);
      dfi_data_i  = (i >= 10 && i <= 13) ? 32'h11 + 32'(i - 10) : 32'd0;
    end
    dfi_valid_i = 1'b0;

    // Fill the FIFO; the 9th word waits for a drain
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      wr_valid_i = 1'b1; wr_data_i = 32'hC0 + k; wr_mask_i = 4'h0;
      #1 chk("fill_rdy", 32'(wr_ready_o), 32'd1);
    end
    @(negedge clock);
    wr_data_i = 32'hC8;
    #1 chk("full_rdy", 32'(wr_ready_o), 32'd0);
    @(negedge clock);
    #1 chk("full_hold", 32'(wr_ready_o), 32'd0);
    issue("wr3", 3'd3, 3'd0, 14'h30);
    wr_burst("wr3", '{32'hC0, 32'hC1, 32'hC2, 32'hC3}, 4'h0);
    issue("wr4", 3'd3, 3'd0, 14'h34);
    wr_burst("wr4", '{32'hC4, 32'hC5, 32'hC6, 32'hC7}, 4'h0);
    for (int k = 0; k < 3; k++) push(32'hD0 + k, 4'h0);
    issue("wr5", 3'd3, 3'd0, 14'h38);
    wr_burst("wr5", '{32'hC8, 32'hD0, 32'hD1, 32'hD2}, 4'h0);

    // Reset in the middle of a write burst
    for (int k = 0; k < 4; k++) push(32'hE0 + k, 4'h0);
    issue("wr6", 3'd3, 3'd0, 14'h40);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      cmd_valid_i = 1'b0;
      cmd_code_i  = 3'd0;
    end
    #1 chk("mid_wren", 32'(dfi_wren_o), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("mrst_wren", 32'(dfi_wren_o), 32'd0);
    chk("mrst_odt", 32'(dfi_odt_o), 32'd0);
    chk("mrst_cmd", 32'(cmd), 32'(4'b0111));
    chk("mrst_wr_rdy", 32'(wr_ready_o), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    cmd_code_i = 3'd3;
    #1;
    chk("post_wr_hold", 32'(cmd_ready_o), 32'd0);
    chk("post_wr_rdy", 32'(wr_ready_o), 32'd1);
    chk("post_wren", 32'(dfi_wren_o), 32'd0);
    cmd_code_i = 3'd0;
    for (int k = 0; k < 4; k++) push(32'hF0 + k, 4'h0);
    issue("wr7", 3'd3, 3'd0, 14'h44);
    wr_burst("wr7", '{32'hF0, 32'hF1, 32'hF2, 32'hF3}, 4'h0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
